// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler that shares one UDP/IPv4/Ethernet TX frame builder
// among N_REQ payload sources. It latches the winner's length and port,
// starts the builder, steers payload pulls to the owner, and then holds off
// the next arbitration for the inter-frame gap.
module udp_tx_scheduler #(
    parameter int N_REQ       = 4,
    parameter int IFG_CYCLES  = 12,
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*16-1:0] req_len,
    input  logic [N_REQ*16-1:0] req_dest_port,
    input  logic [N_REQ*8-1:0]  req_data,
    output logic [N_REQ-1:0]    req_grant,
    output logic [N_REQ-1:0]    req_rd,
    output logic [N_REQ-1:0]    req_done,
    output logic [N_REQ-1:0]    req_drop,
    output logic                tx_start,
    output logic [15:0]         tx_len,
    output logic [15:0]         tx_dest_port,
    input  logic                tx_busy,
    input  logic                tx_payload_req,
    output logic [7:0]          tx_payload_data,
    output logic                len_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int IFG_W = $clog2(IFG_CYCLES + 2);

    typedef enum logic [2:0] {
        ST_ARB,
        ST_START,
        ST_WAIT_BUSY,
        ST_SEND,
        ST_IFG
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   rr_q;
    logic [IDX_W-1:0]   win_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   drop_q;
    logic [N_REQ-1:0]   done_q;
    logic               tx_start_q;
    logic               len_err_q;
    logic [15:0]        tx_len_q;
    logic [15:0]        tx_port_q;
    logic [15:0]        count_q;
    logic [15:0]        count_d;
    logic               over_q;
    logic [IFG_W-1:0]   ifg_q;

    logic               found;
    logic [IDX_W-1:0]   win_idx;
    logic [15:0]        win_len;
    logic [15:0]        win_port;
    logic               pull_ok;

    // Index following w, wrapping at N_REQ (N_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] w);
        return (w == IDX_W'(N_REQ - 1)) ? '0 : w + 1'b1;
    endfunction

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int pos;
            pos = int'(rr_q) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (!found && req_valid[pos[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = pos[IDX_W-1:0];
            end
        end
        win_len  = req_len[int'(win_idx)*16 +: 16];
        win_port = req_dest_port[int'(win_idx)*16 +: 16];
    end

    // Payload steering: strobe only in-range pulls, count all pulls (saturating).
    always_comb begin
        pull_ok         = tx_payload_req && (count_q < tx_len_q);
        req_rd          = (state_q == ST_SEND && pull_ok) ? grant_q : '0;
        count_d         = count_q;
        if (state_q == ST_SEND && tx_payload_req && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
        tx_payload_data = ((|grant_q) && !over_q) ? req_data[int'(win_q)*8 +: 8] : 8'h00;
    end

    // Scheduler FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            rr_q       <= '0;
            win_q      <= '0;
            grant_q    <= '0;
            drop_q     <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            len_err_q  <= 1'b0;
            tx_len_q   <= '0;
            tx_port_q  <= '0;
            count_q    <= '0;
            over_q     <= 1'b0;
            ifg_q      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every read sees the pre-edge value.
            drop_q     <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            len_err_q  <= 1'b0;
            over_q     <= 1'b0;
            unique case (state_q)
                ST_ARB: begin
                    if (found) begin
                        if (win_len == 16'd0 || win_len > 16'(MAX_PAYLOAD)) begin
                            drop_q[win_idx] <= 1'b1;
                            rr_q            <= next_idx(win_idx);
                        end else begin
                            win_q            <= win_idx;
                            grant_q          <= '0;
                            grant_q[win_idx] <= 1'b1;
                            tx_start_q       <= 1'b1;
                            tx_len_q         <= win_len;
                            tx_port_q        <= win_port;
                            state_q          <= ST_START;
                        end
                    end
                end
                ST_START: state_q <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (tx_busy) state_q <= ST_SEND;
                end
                ST_SEND: begin
                    count_q <= count_d;
                    over_q  <= tx_payload_req && !pull_ok;
                    if (!tx_busy) begin
                        done_q[win_q] <= 1'b1;
                        len_err_q     <= (count_d != tx_len_q);
                        rr_q          <= next_idx(win_q);
                        count_q       <= '0;
                        grant_q       <= '0;
                        over_q        <= 1'b0;
                        if (IFG_CYCLES > 0) begin
                            ifg_q   <= IFG_W'(IFG_CYCLES);
                            state_q <= ST_IFG;
                        end else begin
                            state_q <= ST_ARB;
                        end
                    end
                end
                ST_IFG: begin
                    if (ifg_q <= IFG_W'(1)) begin
                        ifg_q   <= '0;
                        state_q <= ST_ARB;
                    end else begin
                        ifg_q <= ifg_q - 1'b1;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    assign req_grant    = grant_q;
    assign req_drop     = drop_q;
    assign req_done     = done_q;
    assign tx_start     = tx_start_q;
    assign tx_len       = tx_len_q;
    assign tx_dest_port = tx_port_q;
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: a simple builder model pulls payload
// bytes; each scenario task checks grants, strobes, pulses and timing.
module tb_udp_tx_scheduler;

    localparam int N   = 4;
    localparam int IFG = 12;
    localparam int MAXP = 1472;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*16-1:0] req_len = '0;
    logic [N*16-1:0] req_dest_port = '0;
    logic [N*8-1:0]  req_data = '0;
    logic [N-1:0]    req_grant, req_rd, req_done, req_drop;
    logic            tx_start, len_err;
    logic [15:0]     tx_len, tx_dest_port;
    logic            tx_busy = 1'b0;
    logic            tx_payload_req = 1'b0;
    logic [7:0]      tx_payload_data;

    int errors = 0;
    int checks = 0;

    udp_tx_scheduler #(.N_REQ(N), .IFG_CYCLES(IFG), .MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_len(req_len), .req_dest_port(req_dest_port),
        .req_data(req_data), .req_grant(req_grant), .req_rd(req_rd),
        .req_done(req_done), .req_drop(req_drop), .tx_start(tx_start),
        .tx_len(tx_len), .tx_dest_port(tx_dest_port), .tx_busy(tx_busy),
        .tx_payload_req(tx_payload_req), .tx_payload_data(tx_payload_data),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [15:0] v);
        req_len[i*16 +: 16] = v;
    endtask

    task automatic set_port(input int i, input logic [15:0] v);
        req_dest_port[i*16 +: 16] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_len = '0; req_dest_port = '0;
        req_data = '0; tx_busy = 1'b0; tx_payload_req = 1'b0;
        cyc(); cyc();
        checks++; if (req_grant !== '0 || req_rd !== '0 || req_done !== '0 || req_drop !== '0) begin
            errors++; $display("FAIL reset_vec: grant=%b rd=%b done=%b drop=%b want all 0", req_grant, req_rd, req_done, req_drop); end
        checks++; if (tx_start !== 1'b0 || len_err !== 1'b0 || tx_len !== 16'h0 || tx_dest_port !== 16'h0 || tx_payload_data !== 8'h0) begin
            errors++; $display("FAIL reset_scalar: start=%b lerr=%b len=%h port=%h data=%h want 0", tx_start, len_err, tx_len, tx_dest_port, tx_payload_data); end
        rst_n = 1'b1;
    endtask

    // Waits for tx_start; n = number of cycles advanced.
    task automatic wait_start(output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < 200) begin
            cyc(); n++;
        end
        checks++; if (tx_start !== 1'b1) begin
            errors++; $display("FAIL start_timeout: tx_start=%b after %0d cycles want 1", tx_start, n); end
    endtask

    // Builder model: called in the tx_start cycle, ends in the cycle after tx_busy falls.
    task automatic run_frame(input int w, input int pulls, input int len, input logic exp_err);
        logic [N-1:0] oh;
        logic [N-1:0] exp_rd;
        logic [7:0]   exp_data;
        oh = '0; oh[w] = 1'b1;
        req_data = {N{8'hEE}};
        cyc();
        checks++; if (tx_start !== 1'b0 || req_grant !== oh) begin
            errors++; $display("FAIL wait_busy: start=%b grant=%b want 0 %b", tx_start, req_grant, oh); end
        tx_busy = 1'b1;
        cyc();
        for (int i = 0; i < pulls; i++) begin
            tx_payload_req = 1'b1;
            #1;
            exp_rd = (i < len) ? oh : '0;
            checks++; if (req_rd !== exp_rd) begin
                errors++; $display("FAIL pull_rd[%0d]: req_rd=%b want %b", i, req_rd, exp_rd); end
            cyc();
            tx_payload_req = 1'b0;
            req_data[w*8 +: 8] = 8'(8'h40 + i);
            #1;
            exp_data = (i < len) ? 8'(8'h40 + i) : 8'h00;
            checks++; if (tx_payload_data !== exp_data) begin
                errors++; $display("FAIL pull_data[%0d]: data=%h want %h", i, tx_payload_data, exp_data); end
            cyc();
        end
        tx_busy = 1'b0;
        #1;
        checks++; if (tx_len !== 16'(len)) begin
            errors++; $display("FAIL len_stable: tx_len=%0d want %0d", tx_len, len); end
        cyc();
        checks++; if (req_done !== oh || len_err !== exp_err || req_grant !== '0) begin
            errors++; $display("FAIL frame_end: done=%b lerr=%b grant=%b want %b %b 0", req_done, len_err, req_grant, oh, exp_err); end
    endtask

    task automatic test_single();
        test_reset();
        set_len(2, 16'd10); set_port(2, 16'h1234); req_valid = 4'b0100;
        cyc();
        checks++; if (tx_start !== 1'b1 || req_grant !== 4'b0100) begin
            errors++; $display("FAIL t1_start: start=%b grant=%b want 1 0100", tx_start, req_grant); end
        checks++; if (tx_len !== 16'd10 || tx_dest_port !== 16'h1234) begin
            errors++; $display("FAIL t1_latch: len=%0d port=%h want 10 1234", tx_len, tx_dest_port); end
        run_frame(2, 10, 10, 1'b0);
        req_valid = '0;
        cyc();
        checks++; if (req_done !== '0 || len_err !== 1'b0) begin
            errors++; $display("FAIL t1_pulse_width: done=%b lerr=%b want 0 0", req_done, len_err); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [N-1:0] oh;
        test_reset();
        for (int i = 0; i < N; i++) set_len(i, 16'd4);
        req_valid = 4'b1111;
        cyc();
        for (int k = 0; k < 5; k++) begin
            oh = '0; oh[k % N] = 1'b1;
            checks++; if (tx_start !== 1'b1 || req_grant !== oh) begin
                errors++; $display("FAIL rr_grant[%0d]: start=%b grant=%b want 1 %b", k, tx_start, req_grant, oh); end
            run_frame(k % N, 4, 4, 1'b0);
            if (k < 4) begin
                wait_start(n);
                checks++; if (n !== IFG + 1) begin
                    errors++; $display("FAIL rr_gap[%0d]: cycles from busy fall to start=%0d want %0d", k, n + 1, IFG + 2); end
            end
        end
    endtask

    task automatic test_drop();
        test_reset();
        set_len(1, 16'd0); set_len(3, 16'd1500); req_valid = 4'b1010;
        cyc();
        checks++; if (req_drop !== 4'b0010 || tx_start !== 1'b0) begin
            errors++; $display("FAIL drop1: drop=%b start=%b want 0010 0", req_drop, tx_start); end
        req_valid[1] = 1'b0;
        cyc();
        checks++; if (req_drop !== 4'b1000 || tx_start !== 1'b0) begin
            errors++; $display("FAIL drop3: drop=%b start=%b want 1000 0", req_drop, tx_start); end
        req_valid[3] = 1'b0;
        cyc();
        checks++; if (req_drop !== 4'b0000 || tx_start !== 1'b0) begin
            errors++; $display("FAIL drop_idle: drop=%b start=%b want 0 0", req_drop, tx_start); end
        set_len(0, 16'd4); set_len(2, 16'd4); req_valid = 4'b0101;
        cyc();
        checks++; if (tx_start !== 1'b1 || req_grant !== 4'b0001) begin
            errors++; $display("FAIL drop_rr_wrap: start=%b grant=%b want 1 0001", tx_start, req_grant); end
        // Length boundary: MAX_PAYLOAD+1 dropped, MAX_PAYLOAD accepted.
        test_reset();
        set_len(0, 16'(MAXP + 1)); req_valid = 4'b0001;
        cyc();
        checks++; if (req_drop !== 4'b0001 || tx_start !== 1'b0) begin
            errors++; $display("FAIL drop_max_plus1: drop=%b start=%b want 0001 0", req_drop, tx_start); end
        set_len(0, 16'(MAXP));
        cyc();
        checks++; if (tx_start !== 1'b1 || req_drop !== 4'b0000 || tx_len !== 16'(MAXP)) begin
            errors++; $display("FAIL accept_max: start=%b drop=%b len=%0d want 1 0000 %0d", tx_start, req_drop, tx_len, MAXP); end
    endtask

    task automatic test_len_err();
        int n;
        test_reset();
        set_len(0, 16'd8); req_valid = 4'b0001;
        cyc();
        checks++; if (tx_start !== 1'b1) begin
            errors++; $display("FAIL t4_start: start=%b want 1", tx_start); end
        run_frame(0, 10, 8, 1'b1);
        wait_start(n);
        run_frame(0, 6, 8, 1'b1);
    endtask

    task automatic test_commit_ifg();
        int n;
        test_reset();
        set_len(0, 16'd5); set_port(0, 16'hBEEF); req_valid = 4'b0001;
        cyc();
        checks++; if (tx_start !== 1'b1 || tx_dest_port !== 16'hBEEF) begin
            errors++; $display("FAIL t5_start: start=%b port=%h want 1 beef", tx_start, tx_dest_port); end
        req_valid = '0; set_len(0, 16'd0); set_port(0, 16'h0);
        run_frame(0, 5, 5, 1'b0);
        checks++; if (tx_dest_port !== 16'hBEEF) begin
            errors++; $display("FAIL t5_port_hold: port=%h want beef", tx_dest_port); end
        set_len(1, 16'd3); set_port(1, 16'h0777);
        cyc(); cyc();
        req_valid = 4'b0010;
        wait_start(n);
        checks++; if (n !== IFG - 1 || req_grant !== 4'b0010 || tx_dest_port !== 16'h0777) begin
            errors++; $display("FAIL t5_ifg_wait: n=%0d grant=%b port=%h want %0d 0010 0777", n, req_grant, tx_dest_port, IFG - 1); end
    endtask

    task automatic test_reset_mid_send();
        int n;
        test_reset();
        set_len(2, 16'd6); req_valid = 4'b0100;
        cyc();
        req_valid = '0;
        run_frame(2, 6, 6, 1'b0);
        set_len(3, 16'd6); req_valid = 4'b1000;
        wait_start(n);
        checks++; if (req_grant !== 4'b1000) begin
            errors++; $display("FAIL t6_grant3: grant=%b want 1000", req_grant); end
        req_valid = '0;
        cyc();
        tx_busy = 1'b1;
        cyc();
        tx_payload_req = 1'b1;
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_grant !== '0 || req_rd !== '0 || tx_start !== 1'b0 || req_done !== '0 || tx_payload_data !== 8'h0) begin
            errors++; $display("FAIL t6_async: grant=%b rd=%b start=%b done=%b data=%h want 0", req_grant, req_rd, tx_start, req_done, tx_payload_data); end
        checks++; if (tx_len !== 16'h0 || tx_dest_port !== 16'h0) begin
            errors++; $display("FAIL t6_async_len: len=%h port=%h want 0 0", tx_len, tx_dest_port); end
        tx_busy = 1'b0; tx_payload_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        set_len(1, 16'd4); set_len(3, 16'd4); req_valid = 4'b1010;
        cyc();
        checks++; if (tx_start !== 1'b1 || req_grant !== 4'b0010 || req_done !== '0) begin
            errors++; $display("FAIL t6_restart: start=%b grant=%b done=%b want 1 0010 0", tx_start, req_grant, req_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_len_err();
        test_commit_ifg();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
